// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Magnitude of a sign-extended operand. The most negative input maps onto
  // its unsigned magnitude, so the caller must keep the full result width.
  function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
    return (v < 0) ? 32'(-v) : 32'(v);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then try to
// subtract the divisor magnitude.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH-1:0] prem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder stays below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the borrow bit gives the comparison result.
  assign shifted  = {prem, bit_in};
  assign trial    = shifted - {1'b0, dvs_mag};
  assign q_bit    = ~trial[WIDTH];
  assign prem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential two's-complement divider. Works on operand magnitudes and
// produces one quotient bit per clock, then applies the signs.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dest_valid,
  input  logic             dest_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t     state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] prem;     // partial remainder
  logic [WIDTH-1:0] dmag;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] vmag;     // divisor magnitude
  logic           sign_q, sign_r;

  logic [WIDTH-1:0] step_rem;
  logic           step_q;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic           dvs_zero;
  logic           last_step;

  assign dvs_zero  = (divisor == '0);
  assign last_step = (cnt == CW'(1));
  assign q_fin     = {dmag[WIDTH-2:0], step_q};
  assign src_ready  = (state == IDLE);
  assign dest_valid = (state == DONE);

  // Operand magnitudes, computed on sign-extended copies so -2^(WIDTH-1)
  // comes out as its unsigned magnitude.
  always_comb begin
    dvd_abs = WIDTH'(abs_mag({{(32-WIDTH){dividend[WIDTH-1]}}, dividend}));
    dvs_abs = WIDTH'(abs_mag({{(32-WIDTH){divisor[WIDTH-1]}}, divisor}));
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem     (prem),
    .bit_in   (dmag[WIDTH-1]),
    .dvs_mag  (vmag),
    .prem_nxt (step_rem),
    .q_bit    (step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (src_valid) state_nxt = dvs_zero ? DONE : CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: if (dest_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registration on the
  // edge that enters DONE. Results hold their value once back in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      prem        <= '0;
      dmag        <= '0;
      vmag        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (src_valid) begin
            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r <= dividend[WIDTH-1];
            dmag   <= dvd_abs;
            vmag   <= dvs_abs;
            prem   <= '0;
            cnt    <= CW'(WIDTH);
            if (dvs_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          prem <= step_rem;
          dmag <= q_fin;
          cnt  <= cnt - CW'(1);
          if (last_step) begin
            quotient    <= sign_q ? -q_fin : q_fin;
            remainder   <= sign_r ? -step_rem : step_rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential 16-bit two's-complement divider; the inverse operation of the team's combinational signed multiplier.
- Restoring algorithm on operand magnitudes, one quotient bit per clock.
- Valid/ready handshake on both the operand side and the result side, so it can sit behind the multiplier in the same arithmetic datapath.
- Produces a truncated quotient, a remainder, and a divide-by-zero flag.

Parameters:
- WIDTH, 16, operand/result width in bits; the bench covers 16 only.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- src_valid  input  1  operands present
- src_ready  output  1  block can accept operands
- dividend  input  WIDTH  signed dividend
- divisor  input  WIDTH  signed divisor
- dest_valid  output  1  result present
- dest_ready  input  1  consumer takes result
- quotient  output  WIDTH  signed quotient
- remainder  output  WIDTH  signed remainder
- div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Reset (sync, active-high, clk edge): state IDLE; src_ready=1; dest_valid=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0.
- Reset has priority over every other event, including reset mid-CALC: the operation in flight is discarded, no result is produced, and IDLE is reached on the next edge.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - src_ready=1, dest_valid=0.
  - On an edge with src_valid=1, latch the operands:
    - sign_q = dividend[MSB] ^ divisor[MSB]; sign_r = dividend[MSB].
    - Store unsigned magnitudes |dividend| and |divisor|. |-2^(WIDTH-1)| = 2^(WIDTH-1) as unsigned.
    - Clear the partial remainder; counter=WIDTH.
  - If divisor==0 go to DONE, otherwise go to CALC.
- CALC:
  - src_ready=0.
  - Each edge: shift {partial_rem, dividend_mag} left by 1; trial = partial_rem_shifted - divisor_mag (WIDTH+1 bits).
  - If trial >= 0, partial_rem=trial and quotient LSB=1; else restore and quotient LSB=0.
  - counter decrements; go to DONE on the edge where counter reaches 0 (exactly WIDTH CALC edges).
- DONE:
  - dest_valid=1. Outputs are registered on entry to DONE and held stable while dest_ready=0.
  - quotient = sign_q ? -q_mag : q_mag; remainder = sign_r ? -r_mag : r_mag. This gives truncation toward zero, with the remainder taking the dividend's sign.
  - On an edge with dest_ready=1, return to IDLE and drop dest_valid. The output data holds its last value.
- Latency: dest_valid is high WIDTH+1 edges after the accepting edge for divisor≠0, and 1 edge after it for divisor=0.
- Throughput: one operation per WIDTH+2 cycles. src_ready and dest_valid are never high together, and there is no bypass.
- Divide by zero: quotient = all ones (-1), remainder = dividend, div_by_zero=1. div_by_zero=0 for every other result.
- Overflow: -2^(WIDTH-1) / -1 gives quotient = -2^(WIDTH-1) (0x8000) and remainder 0. This falls out of the magnitude path with no special case and no flag.
- src_valid while not in IDLE is ignored; the operands are not sampled.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package div_pkg:
  - DIV_WIDTH = 16.
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t.
  - Function abs_mag(signed) returning an unsigned magnitude.
- One combinational sub-module, div_step:
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once and iterated by the FSM.

Test Plan:
- 100 / 7 -> after 17 edges dest_valid=1, quotient=14 (0x000E), remainder=2, div_by_zero=0.
- -100 / 7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2); 100 / -7 -> quotient=0xFFF2, remainder=0x0002.
- 7 / 0 -> dest_valid 1 edge after accept, quotient=0xFFFF, remainder=0x0007, div_by_zero=1.
- -32768 / -1 -> quotient=0x8000, remainder=0, div_by_zero=0.
- 1000 / 3 with dest_ready held 0 for 5 cycles -> quotient=333, remainder=1; outputs and dest_valid stay stable for all 5 cycles; src_ready=0 throughout; IDLE on the first edge with dest_ready=1.
- Start 500 / 9, assert reset on the 6th CALC edge -> next cycle src_ready=1, dest_valid=0, outputs 0. A following 500 / 9 returns quotient=55, remainder=5.
